// File: rtl/ke_round_key_scheduler.sv
// Round-key scheduler: loads a masked master key, drives the key-expansion
// unit through rounds 1..10 (one request per round, each result chained back
// as the next input), stores all round keys and serves them through a
// 1-cycle-latency indexed read port gated by the number of keys stored.
module ke_round_key_scheduler #(
  parameter int D      = 4,
  parameter int NUM_RK = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*(8+D)-1:0]   key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic [16*(8+D)-1:0]   ke_in,
  output logic                  ke_drdy_i,
  output logic                  ke_first_round,
  input  logic [16*(8+D)-1:0]   ke_out,
  input  logic                  ke_drdy_o,
  input  logic                  rk_rd_en,
  input  logic [3:0]            rk_rd_idx,
  output logic [16*(8+D)-1:0]   rk_rd_data,
  output logic                  rk_rd_vld,
  output logic                  rk_rd_err
);

  localparam int         KW       = 16 * (8 + D);
  localparam logic [3:0] LAST_RND = 4'(NUM_RK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t          state, state_nx;
  logic [3:0]      rnd, rnd_nx;
  logic [3:0]      count, count_nx;
  logic [KW-1:0]   key_nx;
  logic            busy_nx, done_nx, kv_nx, drdy_nx, first_nx;
  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [KW-1:0]   wr_data;
  logic [KW-1:0]   rk_mem [NUM_RK];

  // Next-state, counters and buffer write decision for the schedule FSM.
  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    count_nx = count;
    key_nx   = ke_in;
    busy_nx  = busy;
    done_nx  = 1'b0;
    kv_nx    = keys_valid;
    wr_en    = 1'b0;
    wr_idx   = rnd;
    wr_data  = ke_out;
    case (state)
      ST_IDLE: begin
        if (start) begin
          wr_en    = 1'b1;
          wr_idx   = 4'd0;
          wr_data  = key_in;
          key_nx   = key_in;
          rnd_nx   = 4'd1;
          count_nx = 4'd1;
          kv_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (ke_drdy_o) begin
          wr_en    = 1'b1;
          wr_idx   = rnd;
          wr_data  = ke_out;
          key_nx   = ke_out;
          count_nx = rnd + 4'd1;
          if (rnd < LAST_RND) begin
            rnd_nx   = rnd + 4'd1;
            state_nx = ST_ISSUE;
          end else begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            kv_nx    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // The request strobe is registered, so it is raised on entry to ISSUE.
    drdy_nx  = (state_nx == ST_ISSUE);
    first_nx = (state_nx == ST_ISSUE) && (rnd_nx == 4'd1);
  end

  // FSM state, counters and registered control outputs; reset aborts a schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rnd            <= 4'd0;
      count          <= 4'd0;
      ke_in          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      keys_valid     <= 1'b0;
      ke_drdy_i      <= 1'b0;
      ke_first_round <= 1'b0;
    end else begin
      state          <= state_nx;
      rnd            <= rnd_nx;
      count          <= count_nx;
      ke_in          <= key_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      keys_valid     <= kv_nx;
      ke_drdy_i      <= drdy_nx;
      ke_first_round <= first_nx;
    end
  end

  // Round-key buffer; left uncleared on reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) rk_mem[wr_idx] <= wr_data;
  end

  // Read port: one-cycle latency, rejects indices not yet stored (old count
  // is used, so a same-cycle write to the read index still reports an error).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rd_data <= '0;
      rk_rd_vld  <= 1'b0;
      rk_rd_err  <= 1'b0;
    end else if (rk_rd_en && (rk_rd_idx < count)) begin
      rk_rd_data <= rk_mem[rk_rd_idx];
      rk_rd_vld  <= 1'b1;
      rk_rd_err  <= 1'b0;
    end else begin
      rk_rd_data <= '0;
      rk_rd_vld  <= 1'b0;
      rk_rd_err  <= rk_rd_en;
    end
  end

endmodule

// File: tb/tb_ke_round_key_scheduler.sv
// Directed bench for ke_round_key_scheduler with a behavioural expansion unit
// (fixed latency LKE) built from the FIPS-197 round-key table.
module tb_ke_round_key_scheduler;

  localparam int D   = 4;
  localparam int LW  = 8 + D;
  localparam int KW  = 16 * LW;
  localparam int LKE = 7;
  localparam int LAT = 1 + 10 * (1 + LKE);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] key_in;
  logic          busy, done, keys_valid;
  logic [KW-1:0] ke_in;
  logic          ke_drdy_i, ke_first_round;
  logic [KW-1:0] ke_out;
  logic          ke_drdy_o;
  logic          rk_rd_en;
  logic [3:0]    rk_rd_idx;
  logic [KW-1:0] rk_rd_data;
  logic          rk_rd_vld, rk_rd_err;

  logic          model_o = 1'b0, stray_o = 1'b0;
  logic [KW-1:0] model_out = '0, stray_val = '0;
  assign ke_drdy_o = model_o | stray_o;
  assign ke_out    = stray_o ? stray_val : model_out;

  int total = 0, bad = 0, cyc = 0;
  int npulse = 0, nfirst = 0, first_at = 0, nfirst_bad = 0, ndone = 0, done_cyc = 0;
  int start_cyc = 0, mr = 0;
  logic [127:0]  tab [0:10];
  logic [KW-1:0] cur_k = '0;

  ke_round_key_scheduler #(.D(D), .NUM_RK(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .ke_in(ke_in), .ke_drdy_i(ke_drdy_i), .ke_first_round(ke_first_round),
    .ke_out(ke_out), .ke_drdy_o(ke_drdy_o),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(rk_rd_data), .rk_rd_vld(rk_rd_vld), .rk_rd_err(rk_rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] pack(input logic [127:0] k);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[KW-1-LW*i -: LW] = {{D{1'b0}}, k[127-8*i -: 8]};
    return r;
  endfunction

  function automatic logic [127:0] unpack(input logic [KW-1:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[KW-1-LW*i-D -: 8];
    return r;
  endfunction

  function automatic logic [KW-1:0] exp_rk(input logic [KW-1:0] k, input int i);
    return k ^ pack(tab[i]) ^ pack(tab[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, output logic v, output logic e, output logic [KW-1:0] d);
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    tick();
    v = rk_rd_vld;
    e = rk_rd_err;
    d = rk_rd_data;
    rk_rd_en = 1'b0;
  endtask

  task automatic do_start(input logic [KW-1:0] k);
    cur_k     = k;
    key_in    = k;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    tick();
  endtask

  // Handshake monitor
  always @(negedge clk) begin
    if (ke_drdy_i) begin
      npulse++;
      if (ke_first_round) begin
        nfirst++;
        first_at = npulse;
      end
    end
    if (ke_first_round && !ke_drdy_i) nfirst_bad++;
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  // Expansion-unit model: result LKE cycles after each request, aborted by reset
  initial begin
    logic [KW-1:0] req_key;
    logic          aborted;
    forever begin
      @(negedge clk);
      if (ke_drdy_i && rst_n) begin
        if (ke_first_round) mr = 1;
        else mr = mr + 1;
        req_key = ke_in;
        chk("ke_in_req", ke_in, exp_rk(cur_k, mr - 1));
        aborted = 1'b0;
        for (int i = 0; i < LKE; i++) begin
          @(posedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        #1;
        if (!aborted && rst_n && mr <= 10) begin
          model_out = ke_in ^ pack(tab[mr]) ^ pack(tab[mr-1]);
          model_o   = 1'b1;
          chk("ke_in_hold", ke_in, req_key);
          @(posedge clk);
          #1;
          model_o = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          v, e, seen;
    logic [KW-1:0] d, k1, k2, k3;
    int            p0, f0, d0;
    tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k1 = pack(tab[0]);
    k2 = 192'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c;
    k3 = 192'hdead_beef_0bad_f00d_1357_9bdf_2468_ace0_ffff_0000_8001_7ffe;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_rd_en = 1'b0; rk_rd_idx = 4'd0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_kv", keys_valid, 1'b0);
    chk("rst_ke_in", ke_in, '0);
    chk("rst_drdy_i", ke_drdy_i, 1'b0);
    chk("rst_first", ke_first_round, 1'b0);
    chk("rst_rd_data", rk_rd_data, '0);
    chk("rst_rd_vld", rk_rd_vld, 1'b0);
    chk("rst_rd_err", rk_rd_err, 1'b0);
    rst_n = 1'b1;
    tick();
    rd(4'd0, v, e, d);
    chk("empty_rd0_err", e, 1'b1);
    chk("empty_rd0_vld", v, 1'b0);

    // Stray result strobe while idle and empty
    p0 = npulse;
    stray_val = pack(tab[1]); stray_o = 1'b1; tick(); stray_o = 1'b0; tick();
    chk("stray0_busy", busy, 1'b0);
    chk("stray0_pulses", npulse - p0, 0);
    rd(4'd0, v, e, d);
    chk("stray0_rd0_err", e, 1'b1);

    // Full FIPS-197 schedule
    p0 = npulse; f0 = nfirst; d0 = ndone;
    do_start(k1);
    wait_done("fips");
    chk("fips_latency", done_cyc - start_cyc, LAT);
    chk("fips_pulses", npulse - p0, 10);
    chk("fips_first_cnt", nfirst - f0, 1);
    chk("fips_first_at", first_at - p0, 1);
    chk("fips_first_stray", nfirst_bad, 0);
    chk("fips_ndone", ndone - d0, 1);
    chk("fips_kv", keys_valid, 1'b1);
    chk("fips_busy", busy, 1'b0);
    rd(4'd10, v, e, d);
    chk("fips_rk10_vld", v, 1'b1);
    chk("fips_rk10", unpack(d), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd0, v, e, d);
    chk("fips_rk0", d, k1);
    rd(4'd11, v, e, d);
    chk("rd11_err", e, 1'b1);
    rd(4'd12, v, e, d);
    chk("rd12_err", e, 1'b1);
    chk("rd12_data", d, '0);
    tick();
    chk("rd_idle_data", rk_rd_data, '0);
    chk("rd_idle_vld", rk_rd_vld, 1'b0);

    // Early reads around the RK3 strobe, then start while busy
    d0 = ndone;
    do_start(k2);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (model_o && mr == 3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rk3_strobe_seen", seen, 1'b1);
    rk_rd_en = 1'b1; rk_rd_idx = 4'd3;
    tick();
    chk("rd3_same_cycle_err", rk_rd_err, 1'b1);
    tick();
    chk("rd3_early_vld", rk_rd_vld, 1'b1);
    chk("rd3_early_data", rk_rd_data, exp_rk(k2, 3));
    rk_rd_idx = 4'd4;
    tick();
    chk("rd4_early_err", rk_rd_err, 1'b1);
    rk_rd_en = 1'b0;
    chk("busy_mid", busy, 1'b1);
    key_in = k1; start = 1'b1; tick(); start = 1'b0;
    wait_done("busy_start");
    chk("busy_start_latency", done_cyc - start_cyc, LAT);
    repeat (3) tick();
    chk("busy_start_ndone", ndone - d0, 1);
    rd(4'd5, v, e, d);
    chk("k2_rk5", d, exp_rk(k2, 5));
    rd(4'd10, v, e, d);
    chk("k2_rk10", d, exp_rk(k2, 10));

    // Stray result strobe while idle with a full buffer
    p0 = npulse;
    stray_val = pack(tab[7]); stray_o = 1'b1; tick(); stray_o = 1'b0; tick();
    chk("stray1_pulses", npulse - p0, 0);
    chk("stray1_busy", busy, 1'b0);
    chk("stray1_kv", keys_valid, 1'b1);
    rd(4'd10, v, e, d);
    chk("stray1_rk10", d, exp_rk(k2, 10));

    // Back-to-back schedules
    do_start(k1);
    wait_done("b2b_a");
    do_start(k3);
    chk("b2b_kv_drop", keys_valid, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    rd(4'd0, v, e, d);
    chk("b2b_rk0_vld", v, 1'b1);
    chk("b2b_rk0", d, k3);
    rd(4'd1, v, e, d);
    chk("b2b_old_rk1_err", e, 1'b1);
    wait_done("b2b_b");
    rd(4'd10, v, e, d);
    chk("b2b_rk10", d, exp_rk(k3, 10));

    // Reset in the middle of round 5, then a clean schedule
    p0 = npulse;
    do_start(k2);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (npulse - p0 >= 5) break;
    end
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ke_in", ke_in, '0);
    chk("mid_rst_drdy_i", ke_drdy_i, 1'b0);
    chk("mid_rst_kv", keys_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rd(4'd0, v, e, d);
    chk("post_rst_rd0_err", e, 1'b1);
    do_start(k1);
    wait_done("post_rst");
    chk("post_rst_latency", done_cyc - start_cyc, LAT);
    chk("post_rst_kv", keys_valid, 1'b1);
    rd(4'd10, v, e, d);
    chk("post_rst_rk10", unpack(d), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
